image_stream_source: RTL and testbench

Synthesizable pixel-pair source feeding the BMP writer stage. It walks a frame stored in an external pair-wide memory in raster order, top row first. For each pixel it applies a saturating brightness adjustment, or optionally a threshold, and emits two pixels per cycle with an `HSYNC` qualifier. The output matches exactly what the downstream writer consumes: `hsync` plus the six `DATA_WRITE_*` bytes.

---
 rtl/img_pkg.sv | 27 ++
 rtl/pixel_op.sv | 49 ++++
 rtl/image_stream_source.sv | 170 +++++++++++++++++
 tb/tb_image_stream_source.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and default frame constants for the image stream source.
package img_pkg;

  localparam int IMG_WIDTH  = 768;
  localparam int IMG_HEIGHT = 512;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // p0 sits in the upper bits so {R0,G0,B0,R1,G1,B1} maps directly.
  typedef struct packed {
    rgb_t p0;
    rgb_t p1;
  } rgb_pair_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_ACTIVE,
    ST_HBLANK,
    ST_FLUSH
  } stream_state_e;

endpackage

// File: rtl/pixel_op.sv
// Combinational per-pixel operation: saturating brightness offset, or a
// grey-level threshold when built with IMAGE_STREAM_THRESHOLD_EN.
module pixel_op
  import img_pkg::*;
#(
  parameter int VALUE     = 100,
  parameter int SIGN      = 1,
  parameter int THRESHOLD = 90
) (
  input  rgb_t pix_i,
`ifdef IMAGE_STREAM_THRESHOLD_EN
  input  logic thr_mode_i,
`endif
  output rgb_t pix_o
);

  // Saturating add/subtract on one channel, evaluated in 9 bits.
  function automatic logic [7:0] adj(input logic [7:0] x);
    logic [8:0] s;
    s = '0;
    if (SIGN != 0) begin
      s   = {1'b0, x} + 9'(VALUE);
      adj = s[8] ? 8'hff : s[7:0];
    end else begin
      adj = (x < 8'(VALUE)) ? 8'h00 : x - 8'(VALUE);
    end
  endfunction

`ifdef IMAGE_STREAM_THRESHOLD_EN
  logic [9:0] sum;
  assign sum = 10'(pix_i.r) + 10'(pix_i.g) + 10'(pix_i.b);
`endif

  // Select the per-pixel result.
  always_comb begin
    pix_o.r = adj(pix_i.r);
    pix_o.g = adj(pix_i.g);
    pix_o.b = adj(pix_i.b);
`ifdef IMAGE_STREAM_THRESHOLD_EN
    if (thr_mode_i) begin
      // Comparing the sum against 3*THRESHOLD avoids a divide by three.
      pix_o.r = (sum > 10'(3 * THRESHOLD)) ? 8'hff : 8'h00;
      pix_o.g = pix_o.r;
      pix_o.b = pix_o.r;
    end
`endif
  end

endmodule

// File: rtl/image_stream_source.sv
// Raster-order pixel-pair source for the BMP writer: VSYNC window, then
// rows of WIDTH/2 pairs qualified by HSYNC, separated by HSYNC_DELAY blanks.
// Optional threshold mode is enabled by defining IMAGE_STREAM_THRESHOLD_EN.
module image_stream_source
  import img_pkg::*;
#(
  parameter int WIDTH          = IMG_WIDTH,
  parameter int HEIGHT         = IMG_HEIGHT,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int VALUE          = 100,
  parameter int SIGN           = 1,
  parameter int THRESHOLD      = 90,
  localparam int AW            = $clog2(WIDTH * HEIGHT / 2)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [47:0]   mem_rdata,
`ifdef IMAGE_STREAM_THRESHOLD_EN
  input  logic          thr_mode,
`endif
  output logic          VSYNC,
  output logic          HSYNC,
  output logic [7:0]    DATA_R0,
  output logic [7:0]    DATA_G0,
  output logic [7:0]    DATA_B0,
  output logic [7:0]    DATA_R1,
  output logic [7:0]    DATA_G1,
  output logic [7:0]    DATA_B1,
  output logic          busy,
  output logic          ctrl_done
);

  localparam int PAIRS_ROW = WIDTH / 2;
  localparam int CW   = (PAIRS_ROW > 1) ? $clog2(PAIRS_ROW) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DMX0 = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int DMAX = (DMX0 > 2) ? DMX0 : 2;
  localparam int DW   = $clog2(DMAX + 1);

  stream_state_e   state_q;
  logic [DW-1:0]   dcnt_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [AW-1:0]   addr_q;
  logic            vsync_q, busy_q, done_q;
  logic            vld1_q, hsync_q;
  rgb_pair_t       data_q;
  rgb_pair_t       pair_in, pair_d;

  // Frame sequencer: address generation, sync windows and completion.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      vsync_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            dcnt_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            if (START_UP_DELAY == 0) begin
              state_q <= ST_ACTIVE;
            end else begin
              state_q <= ST_VSYNC;
              vsync_q <= 1'b1;
            end
          end
        end
        ST_VSYNC: begin
          if (dcnt_q == DW'(START_UP_DELAY - 1)) begin
            vsync_q <= 1'b0;
            state_q <= ST_ACTIVE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          addr_q <= addr_q + 1'b1;
          if (col_q == CW'(PAIRS_ROW - 1)) begin
            col_q   <= '0;
            row_q   <= row_q + 1'b1;
            dcnt_q  <= '0;
            state_q <= (row_q == RW'(HEIGHT - 1)) ? ST_FLUSH : ST_HBLANK;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        ST_HBLANK: begin
          if (dcnt_q == DW'(HSYNC_DELAY - 1)) begin
            state_q <= ST_ACTIVE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          // Two drain cycles, then the done cycle is spent here so a start
          // coinciding with ctrl_done is not seen by IDLE.
          if (dcnt_q == DW'(2)) begin
            state_q <= ST_IDLE;
          end else begin
            if (dcnt_q == DW'(1)) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pair_in = rgb_pair_t'(mem_rdata);

  pixel_op #(.VALUE(VALUE), .SIGN(SIGN), .THRESHOLD(THRESHOLD)) u_px0 (
    .pix_i      (pair_in.p0),
`ifdef IMAGE_STREAM_THRESHOLD_EN
    .thr_mode_i (thr_mode),
`endif
    .pix_o      (pair_d.p0)
  );

  pixel_op #(.VALUE(VALUE), .SIGN(SIGN), .THRESHOLD(THRESHOLD)) u_px1 (
    .pix_i      (pair_in.p1),
`ifdef IMAGE_STREAM_THRESHOLD_EN
    .thr_mode_i (thr_mode),
`endif
    .pix_o      (pair_d.p1)
  );

  // Two-stage pipeline: stage 1 aligns valid with read data, stage 2
  // registers the processed pair; data holds while no pair is valid.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld1_q  <= 1'b0;
      hsync_q <= 1'b0;
      data_q  <= '0;
    end else begin
      vld1_q  <= (state_q == ST_ACTIVE);
      hsync_q <= vld1_q;
      if (vld1_q) data_q <= pair_d;
    end
  end

  assign mem_addr  = addr_q;
  assign VSYNC     = vsync_q;
  assign HSYNC     = hsync_q;
  assign busy      = busy_q;
  assign ctrl_done = done_q;
  assign DATA_R0   = data_q.p0.r;
  assign DATA_G0   = data_q.p0.g;
  assign DATA_B0   = data_q.p0.b;
  assign DATA_R1   = data_q.p1.r;
  assign DATA_G1   = data_q.p1.g;
  assign DATA_B1   = data_q.p1.b;

endmodule

// File: tb/tb_image_stream_source.sv
// Bench for image_stream_source: an add-mode and a subtract-mode instance
// share stimulus; a frame model predicts sync timing, addresses and pixels.
module tb_image_stream_source;

  localparam int W = 8, H = 2, D = 3, HD = 2, VAL = 100, THR = 90;
  localparam int PR = W / 2, NP = W * H / 2, AW = 3;

  logic HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0, thr_mode = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [AW-1:0]   addr_a, addr_s;
  logic [47:0]     rd_a = '0, rd_s = '0;
  logic            vs_a, hs_a, busy_a, done_a;
  logic            vs_s, hs_s, busy_s, done_s;
  logic [5:0][7:0] da, ds;
  logic [47:0]     mem [NP];

  image_stream_source #(.WIDTH(W), .HEIGHT(H), .START_UP_DELAY(D), .HSYNC_DELAY(HD),
                        .VALUE(VAL), .SIGN(1), .THRESHOLD(THR)) u_add (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mem_addr(addr_a), .mem_rdata(rd_a),
`ifdef IMAGE_STREAM_THRESHOLD_EN
    .thr_mode(thr_mode),
`endif
    .VSYNC(vs_a), .HSYNC(hs_a),
    .DATA_R0(da[5]), .DATA_G0(da[4]), .DATA_B0(da[3]),
    .DATA_R1(da[2]), .DATA_G1(da[1]), .DATA_B1(da[0]),
    .busy(busy_a), .ctrl_done(done_a));

  image_stream_source #(.WIDTH(W), .HEIGHT(H), .START_UP_DELAY(D), .HSYNC_DELAY(HD),
                        .VALUE(VAL), .SIGN(0), .THRESHOLD(THR)) u_sub (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mem_addr(addr_s), .mem_rdata(rd_s),
`ifdef IMAGE_STREAM_THRESHOLD_EN
    .thr_mode(thr_mode),
`endif
    .VSYNC(vs_s), .HSYNC(hs_s),
    .DATA_R0(ds[5]), .DATA_G0(ds[4]), .DATA_B0(ds[3]),
    .DATA_R1(ds[2]), .DATA_G1(ds[1]), .DATA_B1(ds[0]),
    .busy(busy_s), .ctrl_done(done_s));

  // Synchronous memory: data one cycle after the address.
  always @(posedge HCLK) begin
    rd_a <= mem[addr_a];
    rd_s <= mem[addr_s];
  end

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  bit have_frame = 1'b0;
  int s_cyc = 0, done_cyc = 0;
  logic [47:0] q_pairs[$];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit accept(input int n);
    return !have_frame || n > done_cyc;
  endfunction

  function automatic bit issue(input int t);
    int o;
    if (!have_frame) return 1'b0;
    o = t - (s_cyc + D + 1);
    if (o < 0) return 1'b0;
    return (o / (PR + HD) < H) && (o % (PR + HD) < PR);
  endfunction

  function automatic int issue_addr(input int t);
    int o;
    o = t - (s_cyc + D + 1);
    return (o / (PR + HD)) * PR + o % (PR + HD);
  endfunction

  function automatic logic [47:0] ref_pair(input logic [47:0] raw, input bit add, input bit thr);
    int x [6];
    int y;
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) x[i] = int'(raw[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) begin
      if (thr) y = (x[(i/3)*3] + x[(i/3)*3+1] + x[(i/3)*3+2] > 3 * THR) ? 255 : 0;
      else begin
        y = add ? x[i] + VAL : x[i] - VAL;
        if (y > 255) y = 255;
        if (y < 0) y = 0;
      end
      r[47-8*i -: 8] = 8'(y);
    end
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic fill(input int mode);
    int sp [8];
    sp = '{200, 10, 155, 0, 99, 100, 101, 255};
    for (int k = 0; k < NP; k++)
      for (int i = 0; i < 6; i++)
        case (mode)
          0: mem[k][47-8*i -: 8] = 8'(k);
          1: mem[k][47-8*i -: 8] = 8'(sp[(k*6+i)%8]);
          3: mem[k][47-8*i -: 8] = (i == 3 && k[0]) ? 8'd91 : 8'd90;
          default: mem[k][47-8*i -: 8] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic step(input bit st);
    start = st;
    if (st && accept(cyc)) begin
      have_frame = 1'b1;
      s_cyc      = cyc;
      done_cyc   = cyc + D + 1 + H * PR + (H - 1) * HD + 2;
      for (int k = 0; k < NP; k++) q_pairs.push_back(mem[k]);
    end
    @(posedge HCLK); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done();
    while (cyc < done_cyc) step(1'b0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_addr_a"}, 48'(addr_a), 48'd0);
    chk({nm, "_addr_s"}, 48'(addr_s), 48'd0);
    chk({nm, "_vsync"}, 48'({vs_a, vs_s}), 48'd0);
    chk({nm, "_hsync"}, 48'({hs_a, hs_s}), 48'd0);
    chk({nm, "_busy"}, 48'({busy_a, busy_s}), 48'd0);
    chk({nm, "_done"}, 48'({done_a, done_s}), 48'd0);
    chk({nm, "_data_a"}, da, 48'd0);
    chk({nm, "_data_s"}, ds, 48'd0);
  endtask

`ifdef IMAGE_STREAM_THRESHOLD_EN
  initial forever begin
    @(posedge HCLK); #1;
    thr_mode = 1'($urandom_range(0, 1));
  end
`endif

  // ---------------- monitor / scoreboard ----------------
  logic [47:0] last_a = '0, last_s = '0;
  bit thr_prev = 1'b0;

  initial forever begin
    bit ev, eh, eb, ed;
    logic [47:0] raw;
    @(negedge HCLK);
    if (!HRESETn) begin
      last_a = '0; last_s = '0; thr_prev = 1'b0;
    end else begin
      ev = have_frame && cyc >= s_cyc + 1 && cyc <= s_cyc + D;
      eb = have_frame && cyc >= s_cyc + 1 && cyc < done_cyc;
      ed = have_frame && cyc == done_cyc;
      eh = issue(cyc - 2);
      chk("vsync_a", 48'(vs_a), 48'(ev));   chk("vsync_s", 48'(vs_s), 48'(ev));
      chk("hsync_a", 48'(hs_a), 48'(eh));   chk("hsync_s", 48'(hs_s), 48'(eh));
      chk("busy_a", 48'(busy_a), 48'(eb));  chk("busy_s", 48'(busy_s), 48'(eb));
      chk("done_a", 48'(done_a), 48'(ed));  chk("done_s", 48'(done_s), 48'(ed));
      if (issue(cyc)) begin
        chk("addr_a", 48'(addr_a), 48'(issue_addr(cyc)));
        chk("addr_s", 48'(addr_s), 48'(issue_addr(cyc)));
      end
      if (hs_a) begin
        n_chk++;
        if (q_pairs.size() == 0) begin
          n_err++;
          $display("FAIL extra_pair cycle %0d: got pair %0h expected none", cyc, da);
        end else begin
          raw = q_pairs.pop_front();
          chk("data_add", da, ref_pair(raw, 1'b1, thr_prev));
          chk("data_sub", ds, ref_pair(raw, 1'b0, thr_prev));
        end
        last_a = da; last_s = ds;
      end else begin
        chk("hold_a", da, last_a);
        chk("hold_s", ds, last_s);
      end
      thr_prev = thr_mode;
    end
  end

  // ---------------- sequence ----------------
  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    check_zero("reset");
    HRESETn = 1'b1;
    step(1'b0); step(1'b0);

    // Pair index in every byte; then back-to-back frame with saturation bytes:
    // start in the ctrl_done cycle is ignored, the next cycle's is accepted.
    fill(0); step(1'b1); run_to_done();
    fill(1); step(1'b1); step(1'b1); run_to_done();
    step(1'b0);

    // Starts during VSYNC, ACTIVE and HBLANK are ignored.
    fill(3); step(1'b1);
    while (cyc < done_cyc)
      step(cyc == s_cyc + 2 || cyc == s_cyc + D + 2 || cyc == s_cyc + D + 1 + PR + 1);
    step(1'b0);

    // Reset during row 1, then a fresh start replays the whole frame.
    fill(2); step(1'b1);
    while (cyc < s_cyc + D + 1 + PR + HD + 1) step(1'b0);
    #2 HRESETn = 1'b0;
    #1 check_zero("midrst");
    have_frame = 1'b0;
    q_pairs.delete();
    @(posedge HCLK); #1;
    step(1'b0);
    HRESETn = 1'b1;
    repeat (4) step(1'b0);
    step(1'b1); run_to_done();

    // Random starts and data.
    for (int n = 0; n < 400; n++) begin
      if (accept(cyc) && $urandom_range(0, 3) == 0) fill(2);
      step($urandom_range(0, 4) == 0);
    end
    while (cyc <= done_cyc + 2) step(1'b0);

    chk("queue_empty", 48'(q_pairs.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
